axis_quadrature_tracker: RTL

Streaming quadrature position tracker. It turns a two-channel ADC stream (interferometer or encoder A/B signals) into a signed position count at full 4x resolution. Each channel gets its own Schmitt-trigger hysteresis. The block adds direction reporting, glitch (double-transition) detection, output back-pressure and a synchronous clear. It sits between the ADC/filter AXI-Stream chain and the downstream decimation/DMA path.

---
 rtl/quad_tracker_pkg.sv | 39 +++
 rtl/schmitt_trigger.sv | 56 +++++
 rtl/axis_quadrature_tracker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : quad_tracker_pkg
//  Purpose  : Shared encodings for the AXI-Stream quadrature tracker:
//             Schmitt channel states, transition classes and the
//             quadrature transition classifier.
//  Revision : 1.0  initial release
// ============================================================================
package quad_tracker_pkg;

    localparam int ERROR_COUNT_WIDTH = 16;

    // Per-channel Schmitt-trigger state
    localparam logic [1:0] c_ST_UNKNOWN = 2'b00;
    localparam logic [1:0] c_ST_LOW     = 2'b01;
    localparam logic [1:0] c_ST_HIGH    = 2'b10;

    // Quadrature transition classes
    localparam logic [1:0] c_TR_NONE    = 2'b00;
    localparam logic [1:0] c_TR_FWD     = 2'b01;
    localparam logic [1:0] c_TR_REV     = 2'b10;
    localparam logic [1:0] c_TR_ILLEGAL = 2'b11;

    // Codes are {A,B}. Forward order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] classify_transition(input logic [1:0] prev_code,
                                                       input logic [1:0] code);
        logic [1:0] tr;
        tr = c_TR_NONE;
        case ({prev_code, code})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: tr = c_TR_FWD;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: tr = c_TR_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: tr = c_TR_ILLEGAL;
            default:                                tr = c_TR_NONE;
        endcase
        return tr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/schmitt_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : schmitt_trigger
//  Purpose  : Three-state (UNKNOWN/LOW/HIGH) hysteresis comparator for one
//             signed ADC channel. Below the low level goes LOW, otherwise
//             above the high level goes HIGH, otherwise holds. The LOW test
//             has priority so inverted thresholds still behave predictably.
//  Ports    : aclk, aresetn        clock, async active-low reset
//             i_sample             signed sample
//             i_lower_threshold    signed low level
//             i_upper_threshold    signed high level
//             i_update             load o_state_next into the state register
//             o_state              registered channel state
//             o_state_next         state this sample would produce
//  Revision : 1.0  initial release
// ============================================================================
module schmitt_trigger
    import quad_tracker_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic signed [WIDTH-1:0] i_sample,
    input  logic signed [WIDTH-1:0] i_lower_threshold,
    input  logic signed [WIDTH-1:0] i_upper_threshold,
    input  logic                    i_update,
    output logic [1:0]              o_state,
    output logic [1:0]              o_state_next
);

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    always_comb begin
        w_state_next = r_state;
        if (i_sample < i_lower_threshold) begin
            w_state_next = c_ST_LOW;
        end else if (i_sample > i_upper_threshold) begin
            w_state_next = c_ST_HIGH;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_ST_UNKNOWN;
        end else if (i_update) begin
            r_state <= w_state_next;
        end
    end

    assign o_state      = r_state;
    assign o_state_next = w_state_next;

endmodule
`default_nettype wire

// File: rtl/axis_quadrature_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : axis_quadrature_tracker
//  Purpose  : Streaming 4x quadrature position tracker. Each input beat
//             carries an A/B sample pair; each accepted beat produces one
//             output beat with the updated signed position one cycle later.
//  Config   : AXIS_QUADRATURE_TRACKER_SATURATE_EN - when defined, position
//             saturates at the signed limits; otherwise it wraps.
//  Ports    : aclk, aresetn              clock, async active-low reset
//             lower/upper_threshold      shared hysteresis levels
//             log_scale                  step = 2^log_scale per edge
//             clear                      sync clear of position/dir/errors
//             S_AXIS_*                   A (low half) / B (high half) input
//             M_AXIS_*                   signed position output
//             direction                  1 = forward (A leads B)
//             error_count                saturating illegal-transition count
//  Revision : 1.0  initial release
// ============================================================================
module axis_quadrature_tracker
    import quad_tracker_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
    input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
    input  logic [4:0]                           log_scale,
    input  logic                                 clear,
    input  logic                                 S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]        S_AXIS_tdata,
    output logic                                 S_AXIS_tready,
    input  logic                                 M_AXIS_tready,
    output logic                                 M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0]        M_AXIS_tdata,
    output logic                                 direction,
    output logic [ERROR_COUNT_WIDTH-1:0]         error_count
);

    localparam int c_HALF = S_AXIS_TDATA_WIDTH / 2;
    localparam int c_MW   = M_AXIS_TDATA_WIDTH;
    localparam logic [4:0] c_MAX_SHIFT = (c_MW - 2 > 31) ? 5'd31 : 5'(c_MW - 2);
    localparam logic [c_MW-1:0] c_ONE     = c_MW'(1);
    localparam logic [c_MW-1:0] c_POS_MAX = {1'b0, {(c_MW-1){1'b1}}};
    localparam logic [c_MW-1:0] c_POS_MIN = {1'b1, {(c_MW-1){1'b0}}};
`ifdef AXIS_QUADRATURE_TRACKER_SATURATE_EN
    // One guard bit to detect signed overflow before clamping
    localparam int c_SUM_W = c_MW + 1;
`else
    localparam int c_SUM_W = c_MW;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_MW-1:0]              r_position;
    logic                         r_direction;
    logic [ERROR_COUNT_WIDTH-1:0] r_error_count;
    logic                         r_active;
    logic [1:0]                   r_prev_code;
    logic                         r_m_tvalid;
    logic [c_MW-1:0]              r_m_tdata;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s_tready;
    logic w_accept;

    assign w_s_tready = aresetn & (~r_m_tvalid | M_AXIS_tready);
    assign w_accept   = S_AXIS_tvalid & w_s_tready;

    // ------------------------------------------------------------------
    // Schmitt triggers, one per channel
    // ------------------------------------------------------------------
    logic signed [c_HALF-1:0] w_sample_a;
    logic signed [c_HALF-1:0] w_sample_b;
    logic [1:0] w_state_a;
    logic [1:0] w_state_b;
    logic [1:0] w_state_a_next;
    logic [1:0] w_state_b_next;

    assign w_sample_a = S_AXIS_tdata[c_HALF-1:0];
    assign w_sample_b = S_AXIS_tdata[2*c_HALF-1:c_HALF];

    schmitt_trigger #(.WIDTH(c_HALF)) u_schmitt_a (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .i_sample          (w_sample_a),
        .i_lower_threshold (lower_threshold),
        .i_upper_threshold (upper_threshold),
        .i_update          (w_accept),
        .o_state           (w_state_a),
        .o_state_next      (w_state_a_next)
    );

    schmitt_trigger #(.WIDTH(c_HALF)) u_schmitt_b (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .i_sample          (w_sample_b),
        .i_lower_threshold (lower_threshold),
        .i_upper_threshold (upper_threshold),
        .i_update          (w_accept),
        .o_state           (w_state_b),
        .o_state_next      (w_state_b_next)
    );

    // ------------------------------------------------------------------
    // Decoder: works on the post-update channel states so the output beat
    // reflects the sample that produced it.
    // ------------------------------------------------------------------
    logic       w_known;
    logic [1:0] w_code;
    logic [1:0] w_transition;
    logic       w_decode;

    assign w_known      = (w_state_a_next != c_ST_UNKNOWN) && (w_state_b_next != c_ST_UNKNOWN);
    assign w_code       = {w_state_a_next == c_ST_HIGH, w_state_b_next == c_ST_HIGH};
    assign w_transition = classify_transition(r_prev_code, w_code);
    assign w_decode     = w_accept & w_known & r_active;

    // ------------------------------------------------------------------
    // Position accumulator
    // ------------------------------------------------------------------
    logic [4:0]         w_shift;
    logic [c_MW-1:0]    w_step;
    logic [c_SUM_W-1:0] w_pos_ext;
    logic [c_SUM_W-1:0] w_step_ext;
    logic [c_SUM_W-1:0] w_sum;
    logic [c_MW-1:0]    w_pos_stepped;

    assign w_shift    = (log_scale > c_MAX_SHIFT) ? c_MAX_SHIFT : log_scale;
    assign w_step     = c_ONE << w_shift;
    assign w_pos_ext  = c_SUM_W'($signed(r_position));
    assign w_step_ext = c_SUM_W'(w_step);
    assign w_sum      = (w_transition == c_TR_FWD) ? (w_pos_ext + w_step_ext)
                                                   : (w_pos_ext - w_step_ext);

    always_comb begin
`ifdef AXIS_QUADRATURE_TRACKER_SATURATE_EN
        // Guard bit disagreeing with the sign bit means the result left range
        if (w_sum[c_SUM_W-1] != w_sum[c_SUM_W-2]) begin
            w_pos_stepped = w_sum[c_SUM_W-1] ? c_POS_MIN : c_POS_MAX;
        end else begin
            w_pos_stepped = w_sum[c_MW-1:0];
        end
`else
        w_pos_stepped = w_sum;
`endif
    end

    logic [c_MW-1:0]              w_pos_next;
    logic                         w_dir_next;
    logic [ERROR_COUNT_WIDTH-1:0] w_err_next;

    always_comb begin
        w_pos_next = r_position;
        w_dir_next = r_direction;
        w_err_next = r_error_count;
        if (w_decode) begin
            case (w_transition)
                c_TR_FWD: begin
                    w_pos_next = w_pos_stepped;
                    w_dir_next = 1'b1;
                end
                c_TR_REV: begin
                    w_pos_next = w_pos_stepped;
                    w_dir_next = 1'b0;
                end
                c_TR_ILLEGAL: begin
                    if (r_error_count != '1) begin
                        w_err_next = r_error_count + ERROR_COUNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
        // Clear overrides any update from a coincident beat
        if (clear) begin
            w_pos_next = '0;
            w_dir_next = 1'b0;
            w_err_next = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_position    <= '0;
            r_direction   <= 1'b0;
            r_error_count <= '0;
            r_active      <= 1'b0;
            r_prev_code   <= 2'b00;
        end else begin
            r_position    <= w_pos_next;
            r_direction   <= w_dir_next;
            r_error_count <= w_err_next;
            // First known pair seeds the previous code; later pairs
            // (including illegal ones) simply replace it.
            if (w_accept & w_known) begin
                r_active    <= 1'b1;
                r_prev_code <= w_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_pos_next;
        end else if (M_AXIS_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign S_AXIS_tready = w_s_tready;
    assign M_AXIS_tvalid = r_m_tvalid;
    assign M_AXIS_tdata  = r_m_tdata;
    assign direction     = r_direction;
    assign error_count   = r_error_count;

    // The registered channel states are kept for observability only
    logic w_unused;
    assign w_unused = ^{w_state_a, w_state_b};

endmodule
`default_nettype wire
